// File: rtl/quantizer_pkg.sv
// Shared widths and derived constants for the delta-sigma quantizer.
// Step size and top level are derived from the widths so the datapath scales with them.
package quantizer_pkg;

  localparam int DEFAULT_INPUT_WIDTH  = 16;
  localparam int DEFAULT_OUTPUT_WIDTH = 3;

  // Distance between adjacent reconstruction levels.
  function automatic int quant_step(input int input_width, input int output_width);
    return 1 << (input_width - output_width);
  endfunction

  function automatic int max_level(input int output_width);
    return (1 << output_width) - 1;
  endfunction

  typedef logic signed [DEFAULT_INPUT_WIDTH-1:0] quant_err_t;

endpackage

// File: rtl/quantizer_round.sv
// Combinational core: adds the NTF feedback, rounds half-up to a level, saturates,
// and forms the clamped signed quantization error.
module quant_round
  import quantizer_pkg::*;
#(
  parameter int INPUT_WIDTH  = DEFAULT_INPUT_WIDTH,
  parameter int OUTPUT_WIDTH = DEFAULT_OUTPUT_WIDTH
) (
  input  logic [INPUT_WIDTH-1:0]  x_in,
  input  logic [INPUT_WIDTH-1:0]  ntf_in,
  output logic [OUTPUT_WIDTH-1:0] lvl,
  output logic [INPUT_WIDTH-1:0]  err
);

  localparam int SHIFT = INPUT_WIDTH - OUTPUT_WIDTH;
  localparam int WW    = INPUT_WIDTH + 2;

  localparam logic [WW-1:0] HALF_STEP = WW'(quant_step(INPUT_WIDTH, OUTPUT_WIDTH) / 2);
  localparam logic [WW-1:0] MAX_LVL_W = WW'(max_level(OUTPUT_WIDTH));
  localparam logic [OUTPUT_WIDTH-1:0] MAX_LVL = {OUTPUT_WIDTH{1'b1}};
  localparam logic signed [WW-1:0] ERR_MAX = {3'b000, {(INPUT_WIDTH-1){1'b1}}};
  localparam logic signed [WW-1:0] ERR_MIN = {3'b111, {(INPUT_WIDTH-1){1'b0}}};

  logic [INPUT_WIDTH:0]   sum;
  logic [WW-1:0]          rounded;
  logic [WW-1:0]          lvl_wide;
  logic [WW-1:0]          recon;
  logic signed [WW-1:0]   err_wide;

  always_comb begin
    sum      = {1'b0, x_in} + {1'b0, ntf_in};
    // The extra headroom bit keeps the rounding offset from wrapping at full scale.
    rounded  = {1'b0, sum} + HALF_STEP;
    lvl_wide = rounded >> SHIFT;
    lvl      = (lvl_wide > MAX_LVL_W) ? MAX_LVL : lvl_wide[OUTPUT_WIDTH-1:0];
    recon    = {{(WW-OUTPUT_WIDTH){1'b0}}, lvl} << SHIFT;
    err_wide = $signed({1'b0, sum}) - $signed(recon);
    // NOTE: every branch below assigns err, so no latch is inferred.
    if (err_wide > ERR_MAX) begin
      err = ERR_MAX[INPUT_WIDTH-1:0];
    end else if (err_wide < ERR_MIN) begin
      err = ERR_MIN[INPUT_WIDTH-1:0];
    end else begin
      err = err_wide[INPUT_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/quantizer.sv
// Multi-level uniform quantizer for the DEM-DAC path: registers the level code and
// the signed quantization error with one cycle of latency.
module quantizer
  import quantizer_pkg::*;
#(
  parameter int INPUT_WIDTH  = DEFAULT_INPUT_WIDTH,
  parameter int OUTPUT_WIDTH = DEFAULT_OUTPUT_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [INPUT_WIDTH-1:0]  x_in_i,
  input  logic [INPUT_WIDTH-1:0]  ntf_in_i,
  output logic [OUTPUT_WIDTH-1:0] quantized_out_o,
  output logic [INPUT_WIDTH-1:0]  quant_error_o
);

  logic [OUTPUT_WIDTH-1:0] lvl;
  logic [INPUT_WIDTH-1:0]  err;

  quant_round #(
    .INPUT_WIDTH (INPUT_WIDTH),
    .OUTPUT_WIDTH(OUTPUT_WIDTH)
  ) u_round (
    .x_in  (x_in_i),
    .ntf_in(ntf_in_i),
    .lvl   (lvl),
    .err   (err)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      quantized_out_o <= '0;
      quant_error_o   <= '0;
    end else begin
      quantized_out_o <= lvl;
      quant_error_o   <= err;
    end
  end

endmodule

// File: tb/tb_quantizer.sv
// Self-checking bench for quantizer: directed boundary cases plus a randomized stream
// compared every cycle against an arithmetic reference model.
module tb_quantizer;
  import quantizer_pkg::*;

  localparam int IW   = 16;
  localparam int OW   = 3;
  localparam int STEP = 8192;
  localparam int MAXL = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [IW-1:0] x = '0;
  logic [IW-1:0] ntf = '0;
  logic [OW-1:0] code;
  logic [IW-1:0] err_raw;
  quant_err_t    err;

  int vectors     = 0;
  int miscompares = 0;

  assign err = quant_err_t'(err_raw);

  always #5 clk = ~clk;

  quantizer dut (
    .clk_i          (clk),
    .rst_i          (rst_n),
    .x_in_i         (x),
    .ntf_in_i       (ntf),
    .quantized_out_o(code),
    .quant_error_o  (err_raw)
  );

  // Reference: plain integer arithmetic from the quantizer definition.
  function automatic void model(input int xv, input int nv,
                                output int c, output int e, output bit sat);
    int s;
    s   = xv + nv;
    c   = (s + STEP / 2) / STEP;
    sat = (c > MAXL);
    if (sat) c = MAXL;
    e = s - c * STEP;
    if (e > 32767) e = 32767;
    if (e < -32768) e = -32768;
  endfunction

  task automatic check(input string name, input int ac, input int ae,
                       input int ec, input int ee);
    vectors++;
    if (ac != ec || ae != ee) begin
      miscompares++;
      $display("FAIL %s: got code=%0d err=%0d, want code=%0d err=%0d (t=%0t)",
               name, ac, ae, ec, ee, $time);
    end
  endtask

  // Expected outputs after each edge; cleared immediately by reset.
  int exp_code = 0;
  int exp_err  = 0;
  bit exp_sat  = 1'b0;
  bit exp_valid = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_code = 0;
      exp_err  = 0;
      exp_sat  = 1'b0;
    end else begin
      model(int'(x), int'(ntf), exp_code, exp_err, exp_sat);
    end
    if (clk) exp_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (exp_valid) begin
      check("stream", int'(code), int'(err), exp_code, exp_err);
      if (!exp_sat && rst_n) begin
        vectors++;
        if (int'(err) < -STEP / 2 || int'(err) > STEP / 2) begin
          miscompares++;
          $display("FAIL err_bound: got err=%0d, want |err|<=%0d (t=%0t)", int'(err), STEP / 2, $time);
        end
      end
    end
  end

  task automatic apply(input string name, input int xv, input int nv,
                       input int ec, input int ee);
    @(negedge clk);
    x   = IW'(xv);
    ntf = IW'(nv);
    @(negedge clk);
    check(name, int'(code), int'(err), ec, ee);
  endtask

  typedef struct {
    string name;
    int    xv;
    int    nv;
    int    ec;
    int    ee;
  } vec_t;

  vec_t dir[7];

  initial begin
    dir[0] = '{"zero",       0,     0,    0,     0};
    dir[1] = '{"mid",        32768, 1024, 4, 1024};
    dir[2] = '{"saturate",   65535, 8192, 7, 16383};
    dir[3] = '{"half_step",  16384, 4096, 3, -4096};
    dir[4] = '{"lvl1",       8191,  512,  1, 511};
    dir[5] = '{"lvl2_neg",   12345, 256,  2, -3783};
    dir[6] = '{"clamp",      65535, 65535, 7, 32767};

    // Reset held low: asynchronous clear, then held across several edges.
    x   = 16'hBEEF;
    ntf = 16'h1234;
    #1 rst_n = 1'b0;
    #2 check("rst_async", int'(code), int'(err), 0, 0);
    repeat (3) @(negedge clk);
    check("rst_held", int'(code), int'(err), 0, 0);

    // Release: first edge registers the current inputs.
    rst_n = 1'b1;
    x     = 16'd32768;
    ntf   = 16'd1024;
    @(negedge clk);
    check("rst_release", int'(code), int'(err), 4, 1024);

    foreach (dir[i]) apply(dir[i].name, dir[i].xv, dir[i].nv, dir[i].ec, dir[i].ee);

    // Reset pulse mid-stream discards the in-flight sample.
    x   = 16'd40000;
    ntf = 16'd3000;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("rst_pulse_async", int'(code), int'(err), 0, 0);
    @(negedge clk);
    check("rst_pulse_held", int'(code), int'(err), 0, 0);
    rst_n = 1'b1;

    // Randomized stream: full range, low range, and near half-step points.
    for (int n = 0; n < 3000; n++) begin
      int mode;
      int s;
      @(negedge clk);
      mode = int'($urandom_range(0, 3));
      case (mode)
        0: begin
          x   = IW'($urandom);
          ntf = IW'($urandom);
        end
        1: begin
          x   = IW'($urandom_range(0, 40000));
          ntf = IW'($urandom_range(0, 16000));
        end
        default: begin
          s = int'($urandom_range(0, 8)) * STEP + STEP / 2 + int'($urandom_range(0, 2)) - 1;
          if (s > 131070) s = 131070;
          if (s > 65535) begin
            x   = 16'hFFFF;
            ntf = IW'(s - 65535);
          end else begin
            x   = IW'(s);
            ntf = '0;
          end
        end
      endcase
      if ($urandom_range(0, 199) == 0) begin
        #2 rst_n = 1'b0;
        #1 check("rand_rst_async", int'(code), int'(err), 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
